pipe_fill_sequencer: RTL
========================

// Module: pipe_fill_sequencer
// PURPOSE
//  Parametrised pipeline start-up/restart sequencer. After reset it counts fill cycles and
//  qualifies the pipeline (first, valid, done, per-stage valid). Adds stall-hold and a
//  flush -> drain -> refill cycle. Sits beside the pipeline control unit; done gates PC/fetch write-enable.
// PARAMETERS
//  FILL_CYCLES   4   cycles from reset/refill until pipeline is full (>=1)
//  VALID_AT      3   cnt value at/after which valid asserts (1..FILL_CYCLES)
//  DRAIN_CYCLES  2   cycles spent draining after a flush before refill starts (>=1)
//  CNT_W         derived localparam = clog2(FILL_CYCLES+1); not user-set
// PORTS
//  clk          in   1              rising-edge clock
//  rst          in   1              asynchronous, active-low reset (0 = reset)
//  stall        in   1              hold fill/drain progress this cycle
//  flush        in   1              request pipeline restart (sync, single-cycle pulse or level)
//  cnt          out  CNT_W          fill count, 0..FILL_CYCLES, saturates
//  first        out  1              cnt==1 and state FILL or RUN
//  valid        out  1              cnt>=VALID_AT and state!=DRAIN
//  done         out  1              state==RUN (pipeline full)
//  draining     out  1              state==DRAIN
//  stage_valid  out  FILL_CYCLES    bit i = 1 when state!=DRAIN and cnt>i
// BEHAVIOUR
//  - States: FILL, RUN, DRAIN. rst=0 (async): state=FILL, cnt=0, drain_cnt=0; all outputs 0.
//  - All outputs are decodes of registered state/cnt: no input->output combinational path.
//  - FILL: cnt+=1 per cycle unless stall. On the edge where cnt becomes FILL_CYCLES, state->RUN.
//    Default params: first @cycle1, valid @cycle3, done @cycle4 after reset release.
//  - RUN: cnt holds FILL_CYCLES; stall ignored; done=1.
//  - flush (any state, sampled at edge): state->DRAIN, cnt<=0, drain_cnt<=DRAIN_CYCLES-1.
//    flush has priority over stall and over FILL->RUN on the same edge.
//  - DRAIN: drain_cnt-=1 per cycle unless stall; at drain_cnt==0 (no stall, no flush) state->FILL
//    with cnt=0. flush while in DRAIN reloads drain_cnt (restart drain). valid/done/first/stage_valid=0.
//  - cnt never wraps: saturates at FILL_CYCLES. drain_cnt never underflows.
//  - FILL_CYCLES=1: FILL->RUN in one cycle; first and done assert together.
//  - rst asserted mid-operation: immediate return to reset values regardless of state.
// STRUCTURE
//  - Shared package/include: state encodings (ST_FILL=2'd0, ST_RUN=2'd1, ST_DRAIN=2'd2),
//    clog2 function for CNT_W.
//  - One sub-module: sat_counter #(W,MAX) (async active-low reset, clr, en, saturating up-count)
//    for cnt; drain down-counter and FSM inline. State register built from dff cells.
// TESTING (defaults unless stated)
//  - Release rst, no stall/flush -> cnt 1,2,3,4,4..; first only @c1; valid from c3; done from c4.
//  - stall=1 for cycles 2..4 -> cnt holds 2 during stall; valid @c6, done @c7.
//  - flush in RUN -> next cycle draining=1, done=valid=0, cnt=0; 2 cycles later FILL, cnt counts 1..4.
//  - flush+stall same cycle in FILL cnt=2 -> DRAIN entered, cnt=0; repeat flush in DRAIN extends drain.
//  - rst pulsed low mid-DRAIN (async, between edges) -> outputs 0 immediately; refill as from reset.
//  - Param sweep FILL_CYCLES=1,VALID_AT=1 and FILL_CYCLES=7,VALID_AT=5,DRAIN_CYCLES=3 -> timings scale;
//    stage_valid is thermometer of cnt; never exceeds FILL_CYCLES.

Source files
------------

// File: rtl/pipe_fill_sequencer_pkg.sv
// pipe_fill_sequencer_pkg: shared state encodings and width helper for the fill sequencer
package pipe_fill_sequencer_pkg;
  typedef enum logic [1:0] {ST_FILL = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/pipe_fill_sequencer_sat_counter.sv
// sat_counter: saturating up-counter with sync clear; dff: single-bit state cell
module sat_counter #(
  parameter int W   = 3,
  parameter int MAX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= clr ? '0 : (en && cnt != W'(MAX)) ? cnt + W'(1) : cnt;
endmodule

module dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else q <= d;
endmodule

// File: rtl/pipe_fill_sequencer.sv
// pipe_fill_sequencer: pipeline fill/run/drain sequencer qualifying valid and done after reset or flush
module pipe_fill_sequencer
  import pipe_fill_sequencer_pkg::*;
#(
  parameter int FILL_CYCLES  = 4,
  parameter int VALID_AT     = 3,
  parameter int DRAIN_CYCLES = 2,
  localparam int CNT_W       = clog2(FILL_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  output logic [CNT_W-1:0]       cnt,
  output logic                   first,
  output logic                   valid,
  output logic                   done,
  output logic                   draining,
  output logic [FILL_CYCLES-1:0] stage_valid
);
  localparam int DW = clog2(DRAIN_CYCLES + 1);
  state_t state, state_nxt;
  logic [1:0] state_q, state_d;
  logic [DW-1:0] drain_cnt;
  logic fill_step, drain_end, live;
  always_comb begin
    fill_step = state == ST_FILL && !stall && !flush;
    drain_end = state == ST_DRAIN && !stall && !flush && drain_cnt == '0;
    state_nxt = flush ? ST_DRAIN :
                (fill_step && cnt == CNT_W'(FILL_CYCLES - 1)) ? ST_RUN :
                drain_end ? ST_FILL : state;
  end
  assign state_d = state_nxt;
  assign state   = state_t'(state_q);
  for (genvar i = 0; i < 2; i++) begin : g_st
    dff u_dff (.clk(clk), .rst(rst), .d(state_d[i]), .q(state_q[i]));
  end
  sat_counter #(.W(CNT_W), .MAX(FILL_CYCLES)) u_cnt (
    .clk(clk), .rst(rst), .clr(flush), .en(fill_step), .cnt(cnt)
  );
  // flush reloads the drain timer even mid-drain, restarting the drain window
  always_ff @(posedge clk or negedge rst)
    if (!rst) drain_cnt <= '0;
    else if (flush) drain_cnt <= DW'(DRAIN_CYCLES - 1);
    else if (state == ST_DRAIN && !stall && drain_cnt != '0) drain_cnt <= drain_cnt - DW'(1);
  assign live     = state != ST_DRAIN;
  assign first    = cnt == CNT_W'(1) && (state == ST_FILL || state == ST_RUN);
  assign valid    = live && cnt >= CNT_W'(VALID_AT);
  assign done     = state == ST_RUN;
  assign draining = state == ST_DRAIN;
  for (genvar i = 0; i < FILL_CYCLES; i++) begin : g_sv
    assign stage_valid[i] = live && cnt > CNT_W'(i);
  end
endmodule
